// File: rtl/writeback_arbiter_if.sv
// Writeback bus: per-source execute results in, one merged register-file writeback stream out.
// slave = the arbiter side, master = execute units plus the issue-stage consumer.
interface writeback_arbiter_if #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 5
);
    localparam int WID_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DATA_BITS = NUM_THREADS * 32;

    logic [NUM_REQS-1:0]             in_valid;
    logic [NUM_REQS-1:0]             in_ready;
    logic [NUM_REQS*UUID_BITS-1:0]   in_uuid;
    logic [NUM_REQS*WID_BITS-1:0]    in_wid;
    logic [NUM_REQS*32-1:0]          in_PC;
    logic [NUM_REQS*NUM_THREADS-1:0] in_tmask;
    logic [NUM_REQS-1:0]             in_wb;
    logic [NUM_REQS*NR_BITS-1:0]     in_rd;
    logic [NUM_REQS*DATA_BITS-1:0]   in_data;
    logic [NUM_REQS-1:0]             in_eop;

    logic                            wb_valid;
    logic [UUID_BITS-1:0]            wb_uuid;
    logic [WID_BITS-1:0]             wb_wid;
    logic [31:0]                     wb_PC;
    logic [NUM_THREADS-1:0]          wb_tmask;
    logic [NR_BITS-1:0]              wb_rd;
    logic [DATA_BITS-1:0]            wb_data;
    logic                            wb_eop;

    modport slave (
        input  in_valid, in_uuid, in_wid, in_PC, in_tmask, in_wb, in_rd, in_data, in_eop,
        output in_ready,
        output wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop
    );

    modport master (
        output in_valid, in_uuid, in_wid, in_PC, in_tmask, in_wb, in_rd, in_data, in_eop,
        input  in_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin merge of execute-unit results into one registered writeback stream.
// Define WB_ARB_PERF_EN to add the perf_wb_stalls / perf_retired counters.
module writeback_arbiter #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 5
) (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [63:0]         perf_wb_stalls,
    output logic [63:0]         perf_retired
`endif
);
    localparam int WID_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DATA_BITS = NUM_THREADS * 32;
    localparam int RR_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    function automatic logic [RR_BITS-1:0] wrapIdx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQS) s = s - NUM_REQS;
        return RR_BITS'(s);
    endfunction

    logic [RR_BITS-1:0]     r_rr;
    logic                   r_wb_valid;
    logic [UUID_BITS-1:0]   r_wb_uuid;
    logic [WID_BITS-1:0]    r_wb_wid;
    logic [31:0]            r_wb_PC;
    logic [NUM_THREADS-1:0] r_wb_tmask;
    logic [NR_BITS-1:0]     r_wb_rd;
    logic [DATA_BITS-1:0]   r_wb_data;
    logic                   r_wb_eop;

    logic [NUM_REQS-1:0]    w_cand;
    logic [NUM_REQS-1:0]    w_retire;
    logic [NUM_REQS-1:0]    w_grant;
    logic                   w_any;
    logic [RR_BITS-1:0]     w_winner;
    logic [RR_BITS-1:0]     w_rr_next;

    logic [UUID_BITS-1:0]   w_sel_uuid;
    logic [WID_BITS-1:0]    w_sel_wid;
    logic [31:0]            w_sel_PC;
    logic [NUM_THREADS-1:0] w_sel_tmask;
    logic [NR_BITS-1:0]     w_sel_rd;
    logic [DATA_BITS-1:0]   w_sel_data;
    logic                   w_sel_eop;

    assign w_cand   = bus.in_valid & bus.in_wb;
    assign w_retire = bus.in_valid & ~bus.in_wb;

    // First candidate at or after the round-robin pointer wins; no data enters this path.
    always_comb begin
        w_grant  = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_any && w_cand[wrapIdx(int'(r_rr), i)]) begin
                w_any    = 1'b1;
                w_winner = wrapIdx(int'(r_rr), i);
            end
        end
        if (w_any) w_grant[w_winner] = 1'b1;
        w_rr_next = wrapIdx(int'(w_winner), 1);
    end

    assign bus.in_ready = reset ? '0 : (w_retire | w_grant);

    always_comb begin
        w_sel_uuid  = bus.in_uuid [int'(w_winner)*UUID_BITS   +: UUID_BITS];
        w_sel_wid   = bus.in_wid  [int'(w_winner)*WID_BITS    +: WID_BITS];
        w_sel_PC    = bus.in_PC   [int'(w_winner)*32          +: 32];
        w_sel_tmask = bus.in_tmask[int'(w_winner)*NUM_THREADS +: NUM_THREADS];
        w_sel_rd    = bus.in_rd   [int'(w_winner)*NR_BITS     +: NR_BITS];
        w_sel_data  = bus.in_data [int'(w_winner)*DATA_BITS   +: DATA_BITS];
        w_sel_eop   = bus.in_eop  [w_winner];
    end

    // Payload fields hold across idle cycles; only wb_valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_uuid  <= '0;
            r_wb_wid   <= '0;
            r_wb_PC    <= '0;
            r_wb_tmask <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_eop   <= 1'b0;
        end else begin
            r_wb_valid <= w_any;
            if (w_any) begin
                r_rr       <= w_rr_next;
                r_wb_uuid  <= w_sel_uuid;
                r_wb_wid   <= w_sel_wid;
                r_wb_PC    <= w_sel_PC;
                r_wb_tmask <= w_sel_tmask;
                r_wb_rd    <= w_sel_rd;
                r_wb_data  <= w_sel_data;
                r_wb_eop   <= w_sel_eop;
            end
        end
    end

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_uuid  = r_wb_uuid;
    assign bus.wb_wid   = r_wb_wid;
    assign bus.wb_PC    = r_wb_PC;
    assign bus.wb_tmask = r_wb_tmask;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;
    assign bus.wb_eop   = r_wb_eop;

`ifdef WB_ARB_PERF_EN
    logic [63:0] r_perf_stalls;
    logic [63:0] r_perf_retired;
    logic [63:0] w_stall_inc;
    logic [63:0] w_retire_inc;

    // Stalls count losing candidates; retirements count accepted eop packets of either kind.
    always_comb begin
        w_stall_inc  = 64'($countones(w_cand)) - (w_any ? 64'd1 : 64'd0);
        w_retire_inc = 64'($countones((w_retire | w_grant) & bus.in_eop));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stalls  <= '0;
            r_perf_retired <= '0;
        end else begin
            r_perf_stalls  <= r_perf_stalls + w_stall_inc;
            r_perf_retired <= r_perf_retired + w_retire_inc;
        end
    end

    assign perf_wb_stalls = r_perf_stalls;
    assign perf_retired   = r_perf_retired;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: grant order, retire bypass, wrap, multi-packet, async reset.
// Perf counter checks compile in only when WB_ARB_PERF_EN is defined.
module tb_writeback_arbiter;
    localparam int NUM_REQS = 5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
`ifdef WB_ARB_PERF_EN
    logic [63:0] perf_wb_stalls;
    logic [63:0] perf_retired;
    logic [63:0] retBase;
`endif

    writeback_arbiter_if #(.NUM_REQS(5), .NUM_THREADS(4), .NUM_WARPS(4), .UUID_BITS(44), .NR_BITS(5)) bus ();

    writeback_arbiter #(.NUM_REQS(5), .NUM_THREADS(4), .NUM_WARPS(4), .UUID_BITS(44), .NR_BITS(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_wb_stalls (perf_wb_stalls),
        .perf_retired   (perf_retired)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus.in_valid = '0;
        bus.in_uuid  = '0;
        bus.in_wid   = '0;
        bus.in_PC    = '0;
        bus.in_tmask = '0;
        bus.in_wb    = '0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.in_eop   = '0;
    endtask

    // Source s offers one result; wid/PC/tmask derive from s so the winner is identifiable.
    task automatic applyStimulus(input int s, input logic wb, input logic [4:0] rd,
                                 input logic [43:0] uuid, input logic [31:0] data, input logic eop);
        bus.in_valid[s]            = 1'b1;
        bus.in_wb[s]               = wb;
        bus.in_eop[s]              = eop;
        bus.in_rd[s*5 +: 5]        = rd;
        bus.in_uuid[s*44 +: 44]    = uuid;
        bus.in_data[s*128 +: 128]  = {4{data}};
        bus.in_wid[s*2 +: 2]       = 2'(s);
        bus.in_PC[s*32 +: 32]      = 32'h1000 + 32'(s * 16);
        bus.in_tmask[s*4 +: 4]     = 4'(s + 9);
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clearInputs();

        // Reset state, with a request present to show in_ready is held low
        applyStimulus(0, 1'b1, 5'd1, 44'h1, 32'h1, 1'b1);
        #1;
        checkOutput("reset_wb_valid", 128'(bus.wb_valid), 128'd0);
        checkOutput("reset_wb_uuid", 128'(bus.wb_uuid), 128'd0);
        checkOutput("reset_in_ready", 128'(bus.in_ready), 128'd0);
`ifdef WB_ARB_PERF_EN
        checkOutput("reset_perf_stalls", 128'(perf_wb_stalls), 128'd0);
        checkOutput("reset_perf_retired", 128'(perf_retired), 128'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        clearInputs();

        // Single source
        applyStimulus(0, 1'b1, 5'd7, 44'h10, 32'hA5, 1'b1);
        #1;
        checkOutput("single_ready", 128'(bus.in_ready), 128'b00001);
        @(posedge clk); #1;
        checkOutput("single_valid", 128'(bus.wb_valid), 128'd1);
        checkOutput("single_rd", 128'(bus.wb_rd), 128'd7);
        checkOutput("single_uuid", 128'(bus.wb_uuid), 128'h10);
        checkOutput("single_data", 128'(bus.wb_data), {4{32'hA5}});
        checkOutput("single_wid", 128'(bus.wb_wid), 128'd0);
        checkOutput("single_PC", 128'(bus.wb_PC), 128'h1000);
        checkOutput("single_tmask", 128'(bus.wb_tmask), 128'd9);
        checkOutput("single_eop", 128'(bus.wb_eop), 128'd1);
        @(negedge clk);
        clearInputs();
        @(posedge clk); #1;
        checkOutput("single_idle_valid", 128'(bus.wb_valid), 128'd0);
        checkOutput("single_idle_rd_hold", 128'(bus.wb_rd), 128'd7);

        // Fairness from rr=0 with all five sources contending
        @(negedge clk);
        resetPulse();
        for (int s = 0; s < NUM_REQS; s++) applyStimulus(s, 1'b1, 5'(s + 16), 44'(s), 32'(s), 1'b1);
        #1;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("fair_ready_%0d", k), 128'(bus.in_ready), 128'(5'b1 << (k % 5)));
            @(posedge clk); #1;
            checkOutput($sformatf("fair_valid_%0d", k), 128'(bus.wb_valid), 128'd1);
            checkOutput($sformatf("fair_rd_%0d", k), 128'(bus.wb_rd), 128'(16 + (k % 5)));
`ifdef WB_ARB_PERF_EN
            checkOutput($sformatf("fair_stalls_%0d", k), 128'(perf_wb_stalls), 128'(4 * (k + 1)));
`endif
            @(negedge clk);
            #1;
        end

        // Non-writing CSR retires alongside the LSU grant
        clearInputs();
        resetPulse();
        applyStimulus(2, 1'b0, 5'd2, 44'h222, 32'h22, 1'b1);
        applyStimulus(1, 1'b1, 5'd9, 44'h111, 32'h11, 1'b1);
        #1;
        checkOutput("nowb_ready", 128'(bus.in_ready), 128'b00110);
        @(posedge clk); #1;
        checkOutput("nowb_valid", 128'(bus.wb_valid), 128'd1);
        checkOutput("nowb_rd", 128'(bus.wb_rd), 128'd9);
        checkOutput("nowb_uuid", 128'(bus.wb_uuid), 128'h111);
`ifdef WB_ARB_PERF_EN
        checkOutput("nowb_retired", 128'(perf_retired), 128'd2);
`endif

        // Wrap-around: walk rr to 4, then 4 and 0 contend
        @(negedge clk);
        clearInputs();
        applyStimulus(3, 1'b1, 5'd13, 44'h333, 32'h33, 1'b1);
        #1;
        checkOutput("wrap_pre_ready", 128'(bus.in_ready), 128'b01000);
        @(posedge clk); #1;
        checkOutput("wrap_pre_rd", 128'(bus.wb_rd), 128'd13);
        @(negedge clk);
        clearInputs();
        applyStimulus(4, 1'b1, 5'd14, 44'h444, 32'h44, 1'b1);
        applyStimulus(0, 1'b1, 5'd20, 44'h400, 32'h40, 1'b1);
        #1;
        checkOutput("wrap_ready_4", 128'(bus.in_ready), 128'b10000);
        @(posedge clk); #1;
        checkOutput("wrap_rd_4", 128'(bus.wb_rd), 128'd14);
        @(negedge clk);
        bus.in_valid[4] = 1'b0;
        #1;
        checkOutput("wrap_ready_0", 128'(bus.in_ready), 128'b00001);
        @(posedge clk); #1;
        checkOutput("wrap_rd_0", 128'(bus.wb_rd), 128'd20);
        checkOutput("wrap_valid_0", 128'(bus.wb_valid), 128'd1);
        @(negedge clk);
        clearInputs();
        applyStimulus(0, 1'b1, 5'd21, 44'h401, 32'h41, 1'b1);
        applyStimulus(1, 1'b1, 5'd22, 44'h402, 32'h42, 1'b1);
        #1;
        checkOutput("wrap_rr_is_1", 128'(bus.in_ready), 128'b00010);
        @(posedge clk); #1;
        checkOutput("wrap_rr_rd", 128'(bus.wb_rd), 128'd22);

        // Multi-packet LSU interleaves with a competing ALU; rr primed to 1
        @(negedge clk);
        clearInputs();
        resetPulse();
        applyStimulus(0, 1'b1, 5'd1, 44'h1, 32'h1, 1'b1);
        @(posedge clk); #1;
        checkOutput("mp_prime_rd", 128'(bus.wb_rd), 128'd1);
        @(negedge clk);
`ifdef WB_ARB_PERF_EN
        retBase = perf_retired;
`endif
        clearInputs();
        applyStimulus(1, 1'b1, 5'd11, 44'h5A, 32'h11, 1'b0);
        applyStimulus(0, 1'b1, 5'd3, 44'hA0, 32'h03, 1'b0);
        #1;
        checkOutput("mp_ready_a", 128'(bus.in_ready), 128'b00010);
        @(posedge clk); #1;
        checkOutput("mp_rd_a", 128'(bus.wb_rd), 128'd11);
        checkOutput("mp_eop_a", 128'(bus.wb_eop), 128'd0);
        @(negedge clk);
        applyStimulus(1, 1'b1, 5'd12, 44'h5A, 32'h12, 1'b1);
        #1;
        checkOutput("mp_ready_b", 128'(bus.in_ready), 128'b00001);
        @(posedge clk); #1;
        checkOutput("mp_rd_b", 128'(bus.wb_rd), 128'd3);
        @(negedge clk);
        bus.in_valid[0] = 1'b0;
        #1;
        checkOutput("mp_ready_c", 128'(bus.in_ready), 128'b00010);
        @(posedge clk); #1;
        checkOutput("mp_rd_c", 128'(bus.wb_rd), 128'd12);
        checkOutput("mp_eop_c", 128'(bus.wb_eop), 128'd1);
        checkOutput("mp_valid_c", 128'(bus.wb_valid), 128'd1);
`ifdef WB_ARB_PERF_EN
        checkOutput("mp_retired", 128'(perf_retired - retBase), 128'd1);
`endif

        // Asynchronous reset while wb_valid is high; rr would otherwise favour source 4
        @(negedge clk);
        clearInputs();
        applyStimulus(3, 1'b1, 5'd15, 44'h777, 32'h77, 1'b1);
        @(posedge clk); #1;
        checkOutput("mid_pre_valid", 128'(bus.wb_valid), 128'd1);
        applyStimulus(0, 1'b1, 5'd5, 44'h55, 32'h55, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_valid", 128'(bus.wb_valid), 128'd0);
        checkOutput("mid_rd", 128'(bus.wb_rd), 128'd0);
        checkOutput("mid_uuid", 128'(bus.wb_uuid), 128'd0);
        checkOutput("mid_data", 128'(bus.wb_data), 128'd0);
        checkOutput("mid_PC", 128'(bus.wb_PC), 128'd0);
        checkOutput("mid_tmask", 128'(bus.wb_tmask), 128'd0);
        checkOutput("mid_eop", 128'(bus.wb_eop), 128'd0);
        checkOutput("mid_in_ready", 128'(bus.in_ready), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        clearInputs();
        applyStimulus(2, 1'b1, 5'd18, 44'h888, 32'h88, 1'b1);
        applyStimulus(4, 1'b1, 5'd19, 44'h999, 32'h99, 1'b1);
        #1;
        checkOutput("post_reset_ready", 128'(bus.in_ready), 128'b00100);
        @(posedge clk); #1;
        checkOutput("post_reset_valid", 128'(bus.wb_valid), 128'd1);
        checkOutput("post_reset_rd", 128'(bus.wb_rd), 128'd18);

        @(negedge clk);
        clearInputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
